// File: rtl/tcdm_axi_bridge_pkg.sv
// Shared types and constants for the TCDM-to-AXI bridge: AXI4 channel structs,
// the issue-slot state encoding and the AXI field encodings the bridge emits.
package tcdm_axi_bridge_pkg;

  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 8;
  localparam int unsigned AxiUserWidth = 1;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  typedef enum logic [1:0] {
    StIdle,
    StArPend,
    StWrPend
  } slot_state_e;

endpackage

// File: rtl/tcdm_axi_lane_fifo.sv
// 1-bit FIFO remembering which 32b lane each outstanding read targets.
// Push and pop in the same cycle are allowed even when full.
module tcdm_axi_lane_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Depth-1:0]    mem_q, mem_d;
  logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer/count next state.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tcdm_to_axi_bridge.sv
// Converts single-port TCDM requests into single-beat AXI4 reads/writes.
// One issue slot holds the granted request until its AXI address/data handshakes
// complete; all in-flight transactions share one direction, so responses retire in order.
module tcdm_to_axi_bridge
  import tcdm_axi_bridge_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 8,
  parameter int unsigned AxiId          = 0,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic        tcdm_r_valid_o,
  output logic [31:0] tcdm_r_data_o,
  output axi_req_t    axi_req_o,
  input  axi_rsp_t    axi_rsp_i,
  output logic        err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  slot_state_e         slot_q, slot_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [29:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_after;
  logic                dir_rd_q, dir_rd_d;
  logic                err_q, err_d;
  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_data_q, r_data_d;

  logic aw_valid, w_valid, ar_valid;
  logic aw_hs, w_hs, ar_hs, slot_free;
  logic b_ret, r_ret, orphan, rsp_err, gnt;
  logic lane, lane_full, lane_empty;

  assign aw_valid = (slot_q == StWrPend) & ~aw_done_q;
  assign w_valid  = (slot_q == StWrPend) & ~w_done_q;
  assign ar_valid = (slot_q == StArPend);
  assign aw_hs    = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs     = w_valid & axi_rsp_i.w_ready;
  assign ar_hs    = ar_valid & axi_rsp_i.ar_ready;

  // Responses only retire when they match the direction in flight; anything else is an orphan.
  assign b_ret   = axi_rsp_i.b_valid & (cnt_q != '0) & ~dir_rd_q;
  assign r_ret   = axi_rsp_i.r_valid & (cnt_q != '0) & dir_rd_q;
  assign orphan  = (axi_rsp_i.b_valid & ~b_ret) | (axi_rsp_i.r_valid & ~r_ret);
  assign rsp_err = (b_ret & (axi_rsp_i.b.resp != AXI_RESP_OKAY)) |
                   (r_ret & (axi_rsp_i.r.resp != AXI_RESP_OKAY));

  // Count as seen after this cycle's retirement, so a grant can coincide with a response.
  assign cnt_after = cnt_q - CntWidth'(b_ret | r_ret);

  // Slot frees in the cycle its last handshake completes.
  always_comb begin
    slot_free = 1'b0;
    unique case (slot_q)
      StIdle:   slot_free = 1'b1;
      StArPend: slot_free = ar_hs;
      StWrPend: slot_free = (aw_done_q | aw_hs) & (w_done_q | w_hs);
      default:  slot_free = 1'b0;
    endcase
  end

  assign gnt = tcdm_req_i & slot_free & (cnt_after < CntMax) &
               ((cnt_after == '0) | (dir_rd_q == tcdm_wen_i));
  assign tcdm_gnt_o = gnt;

  // Issue slot, outstanding count and response next state.
  always_comb begin
    slot_d    = slot_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    dir_rd_d  = dir_rd_q;
    if (slot_free) begin
      slot_d = StIdle;
    end
    if (gnt) begin
      slot_d    = tcdm_wen_i ? StArPend : StWrPend;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      addr_d    = tcdm_add_i[31:2];
      wdata_d   = tcdm_data_i;
      be_d      = tcdm_be_i;
      dir_rd_d  = tcdm_wen_i;
    end
    cnt_d     = cnt_after + CntWidth'(gnt);
    err_d     = err_q | orphan | rsp_err;
    r_valid_d = r_ret;
    r_data_d  = r_data_q;
    if (r_ret) begin
      r_data_d = lane ? axi_rsp_i.r.data[63:32] : axi_rsp_i.r.data[31:0];
    end
  end

  // Bridge state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q    <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      dir_rd_q  <= 1'b0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      slot_q    <= slot_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      dir_rd_q  <= dir_rd_d;
      err_q     <= err_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  tcdm_axi_lane_fifo #(
    .Depth (MaxOutstanding)
  ) u_lane_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt & tcdm_wen_i),
    .data_i  (tcdm_add_i[2]),
    .pop_i   (r_ret),
    .data_o  (lane),
    .full_o  (lane_full),
    .empty_o (lane_empty)
  );

  // AXI request channels driven straight from the issue slot.
  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = AxiIdWidth'(IdWidth'(AxiId));
    axi_req_o.aw.addr   = AxiAddrWidth'(AddrWidth'({addr_q, 2'b00}));
    axi_req_o.aw.size   = AXI_SIZE_4B;
    axi_req_o.aw.burst  = AXI_BURST_INCR;
    axi_req_o.aw_valid  = aw_valid;
    axi_req_o.ar        = axi_req_o.aw;
    axi_req_o.ar_valid  = ar_valid;
    axi_req_o.w.data    = {(DataWidth / 32){wdata_q}};
    axi_req_o.w.strb    = addr_q[0] ? {be_q, 4'b0000} : {4'b0000, be_q};
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w_valid   = w_valid;
    axi_req_o.b_ready   = 1'b1;
    axi_req_o.r_ready   = 1'b1;
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign err_o          = err_q;

  logic unused_sigs;
  assign unused_sigs = ^{axi_rsp_i.b.id, axi_rsp_i.r.id, axi_rsp_i.r.last, lane_full, lane_empty};

endmodule
